// File: rtl/clk_div_pkg.sv
// clk_div_pkg: shared types and helpers for the programmable clock divider.
//   state_t         : divider FSM states (IDLE, RUN, DRAIN)
//   MAX_DIV_DEF     : default largest legal ratio
//   DEFAULT_DIV_DEF : default ratio loaded at reset
//   div_legal()     : ratio legality check, 2 <= value <= max
package clk_div_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int MAX_DIV_DEF     = 20;
  localparam int DEFAULT_DIV_DEF = 4;

  function automatic logic div_legal(input int value, input int max);
    return (value >= 2) && (value <= max);
  endfunction

endpackage

// File: rtl/clk_div_core.sv
// clk_div_core: period counter, wrap detect, phase compare and output flops.
// Optional macro CLK_DIV_PROG_ODD_DUTY50_EN adds a negedge stage that stretches
// the high phase of odd ratios by half a clk_in cycle (exact 50% duty).
// Ports:
//   clk_in, rst : clock, synchronous active-high reset
//   active      : FSM currently not IDLE (counter advances)
//   run_nxt     : FSM will be not IDLE after this edge
//   div         : ratio of the period in progress
//   div_nxt     : ratio that applies after this edge (differs only at apply)
//   wrap        : last cycle of the current period
//   clk_out     : divided clock
//   tick        : first cycle of each high phase
module clk_div_core #(
  parameter int DIV_W = 5
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             active,
  input  logic             run_nxt,
  input  logic [DIV_W-1:0] div,
  input  logic [DIV_W-1:0] div_nxt,
  output logic             wrap,
  output logic             clk_out,
  output logic             tick
);

  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] cnt_nxt;
  logic             clk_p;

  assign wrap    = active && (cnt == div - DIV_W'(1));
  // IDLE holds the counter at 0, so a start always begins a fresh period.
  assign cnt_nxt = (!active || wrap) ? '0 : cnt + DIV_W'(1);

  // Outputs are computed from the post-edge count so they stay aligned
  // with cnt while still coming straight from flops.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      cnt   <= '0;
      clk_p <= 1'b0;
      tick  <= 1'b0;
    end else begin
      cnt   <= cnt_nxt;
      clk_p <= run_nxt && (cnt_nxt < (div_nxt >> 1));
      tick  <= run_nxt && (cnt_nxt == '0);
    end
  end

`ifdef CLK_DIV_PROG_ODD_DUTY50_EN
  // Holds the high phase half a cycle past clk_p's fall for odd ratios.
  logic clk_n;
  always_ff @(negedge clk_in) begin
    if (rst) clk_n <= 1'b0;
    else     clk_n <= clk_p & div[0];
  end
  assign clk_out = clk_p | clk_n;
`else
  assign clk_out = clk_p;
`endif

endmodule

// File: rtl/clk_div_prog.sv
// clk_div_prog: runtime-programmable integer clock divider, N in [2, MAX_DIV].
// New ratios arrive over a valid/ready handshake and take effect only at a
// period boundary. Optional macro CLK_DIV_PROG_ODD_DUTY50_EN gives exact 50%
// duty for odd ratios (see clk_div_core).
// Ports:
//   clk_in, rst : clock, synchronous active-high reset
//   en          : run request (level)
//   div_in      : requested ratio; div_valid/div_ready handshake
//   div_err     : one-cycle pulse after an illegal ratio was taken
//   div_active  : ratio in use
//   clk_out     : divided clock; tick marks the first cycle of each high phase
//   running     : FSM not IDLE
module clk_div_prog
  import clk_div_pkg::*;
#(
  parameter  int MAX_DIV     = MAX_DIV_DEF,
  parameter  int DEFAULT_DIV = DEFAULT_DIV_DEF,
  localparam int DIV_W       = $clog2(MAX_DIV + 1)
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             en,
  input  logic [DIV_W-1:0] div_in,
  input  logic             div_valid,
  output logic             div_ready,
  output logic             div_err,
  output logic [DIV_W-1:0] div_active,
  output logic             clk_out,
  output logic             tick,
  output logic             running
);

  state_t           state, state_nxt;
  logic             wrap;
  logic             pend_vld;
  logic [DIV_W-1:0] pend;
  logic [DIV_W-1:0] div_nxt;
  logic             xfer;
  logic             legal;
  logic             apply;

  assign div_ready = !pend_vld;
  assign xfer      = div_valid && div_ready;
  assign legal     = div_legal(int'(div_in), MAX_DIV);
  assign running   = (state != IDLE);

  // Pending ratio lands immediately when idle, otherwise on the wrap edge.
  // A ratio taken during the wrap cycle is not yet pending, so it waits
  // for the following wrap.
  assign apply   = pend_vld && ((state == IDLE) || wrap);
  assign div_nxt = apply ? pend : div_active;

  always_ff @(posedge clk_in) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Stopping only happens at a wrap, so no phase is ever truncated.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:       if (en) state_nxt = RUN;
      RUN, DRAIN: if (en)        state_nxt = RUN;
                  else if (wrap) state_nxt = IDLE;
                  else           state_nxt = DRAIN;
      default:    state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      div_active <= DIV_W'(DEFAULT_DIV);
      pend_vld   <= 1'b0;
      pend       <= '0;
      div_err    <= 1'b0;
    end else begin
      div_active <= div_nxt;
      div_err    <= xfer && !legal;
      // apply needs pend_vld=1 and xfer needs pend_vld=0: never both.
      if (apply) begin
        pend_vld <= 1'b0;
      end else if (xfer && legal) begin
        pend_vld <= 1'b1;
        pend     <= div_in;
      end
    end
  end

  clk_div_core #(
    .DIV_W(DIV_W)
  ) u_core (
    .clk_in  (clk_in),
    .rst     (rst),
    .active  (running),
    .run_nxt (state_nxt != IDLE),
    .div     (div_active),
    .div_nxt (div_nxt),
    .wrap    (wrap),
    .clk_out (clk_out),
    .tick    (tick)
  );

endmodule

// File: tb/tb_clk_div_prog.sv
// tb_clk_div_prog: directed scenarios followed by randomized en/ratio/reset
// traffic, checked every cycle against a period-position reference model.
module tb_clk_div_prog;
  localparam int MAX_DIV     = 20;
  localparam int DEFAULT_DIV = 4;
  localparam int DIV_W       = $clog2(MAX_DIV + 1);

  logic             clk_in = 1'b0;
  logic             rst, en, div_valid;
  logic [DIV_W-1:0] div_in;
  logic             div_ready, div_err, clk_out, tick, running;
  logic [DIV_W-1:0] div_active;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk_in = ~clk_in;

  clk_div_prog #(.MAX_DIV(MAX_DIV), .DEFAULT_DIV(DEFAULT_DIV)) dut (
    .clk_in     (clk_in),
    .rst        (rst),
    .en         (en),
    .div_in     (div_in),
    .div_valid  (div_valid),
    .div_ready  (div_ready),
    .div_err    (div_err),
    .div_active (div_active),
    .clk_out    (clk_out),
    .tick       (tick),
    .running    (running)
  );

  // Reference: running flag, position within the current period, ratio of
  // the current period, one pending slot, and the source's request queue.
  bit m_run;
  int m_pos;
  int m_n;
  bit m_pv;
  int m_pd;
  bit m_err;
  int reqs[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic cyc(input bit r, input bit e);
    bit v, acc, ill, ending;
    int d;
    v = !r && (reqs.size() > 0);
    d = v ? reqs[0] : 0;
    rst = r; en = e; div_valid = v; div_in = DIV_W'(d);
    @(posedge clk_in);
    if (r) begin
      m_run = 0; m_pos = 0; m_n = DEFAULT_DIV; m_pv = 0; m_err = 0;
    end else begin
      acc    = v && !m_pv;
      ill    = (d < 2) || (d > MAX_DIV);
      ending = m_run && (m_pos == m_n - 1);
      if (m_pv && (!m_run || ending)) begin
        m_n  = m_pd;
        m_pv = 0;
      end else if (acc && !ill) begin
        m_pv = 1;
        m_pd = d;
      end
      m_err = acc && ill;
      if (acc) void'(reqs.pop_front());
      if (!m_run) begin
        if (e) begin m_run = 1; m_pos = 0; end
      end else if (ending) begin
        m_pos = 0;
        m_run = e;
      end else begin
        m_pos++;
      end
    end
    #1;
    chk("clk_out",    32'(clk_out),    32'(m_run && (m_pos < m_n / 2)));
    chk("tick",       32'(tick),       32'(m_run && (m_pos == 0)));
    chk("running",    32'(running),    32'(m_run));
    chk("div_active", 32'(div_active), 32'(m_n));
    chk("div_ready",  32'(div_ready),  32'(!m_pv));
    chk("div_err",    32'(div_err),    32'(m_err));
  endtask

  task automatic run(input int n, input bit e);
    for (int i = 0; i < n; i++) cyc(1'b0, e);
  endtask

  initial begin
    bit e;
    rst = 1'b1; en = 1'b0; div_valid = 1'b0; div_in = '0;
    // reset state
    cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b0);
    run(3, 1'b0);
    // default ratio 4
    run(13, 1'b1);
    // ratio 5 mid-period
    reqs.push_back(5);
    run(16, 1'b1);
    // illegal ratios below and above the legal range
    reqs.push_back(1);
    reqs.push_back(21);
    reqs.push_back(0);
    run(12, 1'b1);
    // back-to-back requests: second stalls until the first applies
    reqs.push_back(6);
    reqs.push_back(8);
    run(30, 1'b1);
    // stop mid-high at N=6, re-enable during drain, then full stop
    reqs.push_back(6);
    run(20, 1'b1);
    run(2, 1'b0);
    run(10, 1'b1);
    run(1, 1'b1);
    run(16, 1'b0);
    // ratio loaded while idle, then restart at the boundary values
    reqs.push_back(2);
    run(3, 1'b0);
    run(10, 1'b1);
    reqs.push_back(MAX_DIV);
    run(45, 1'b1);
    // reset mid-period
    cyc(1'b1, 1'b1);
    run(10, 1'b1);
    // randomized traffic
    e = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 15) == 0) e = !e;
      if (reqs.size() == 0 && $urandom_range(0, 9) == 0)
        reqs.push_back(($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31))
                                                   : int'($urandom_range(2, MAX_DIV)));
      cyc($urandom_range(0, 499) == 0, e);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
